// File: rtl/cd_csr_pkg.sv
// Shared definitions for the CD CSR block: register map, int_flag bit
// positions, reset values and a small sticky-flag helper.
package cd_csr_pkg;

  // Register word addresses
  localparam logic [4:0] ADDR_VERSION   = 5'h00;
  localparam logic [4:0] ADDR_SETTING   = 5'h01;
  localparam logic [4:0] ADDR_IDLE_WAIT = 5'h02;
  localparam logic [4:0] ADDR_TX_PERMIT = 5'h03;
  localparam logic [4:0] ADDR_MAX_IDLE  = 5'h04;
  localparam logic [4:0] ADDR_TX_PRE    = 5'h05;
  localparam logic [4:0] ADDR_FILTER    = 5'h06;
  localparam logic [4:0] ADDR_DIV_LS    = 5'h07;
  localparam logic [4:0] ADDR_DIV_HS    = 5'h08;
  localparam logic [4:0] ADDR_INT_MASK  = 5'h09;
  localparam logic [4:0] ADDR_INT_FLAG  = 5'h0A;
  localparam logic [4:0] ADDR_RX        = 5'h0B;
  localparam logic [4:0] ADDR_TX        = 5'h0C;
  localparam logic [4:0] ADDR_RX_CTRL   = 5'h0D;
  localparam logic [4:0] ADDR_TX_CTRL   = 5'h0E;
  localparam logic [4:0] ADDR_FILTER_M  = 5'h0F;
  localparam logic [4:0] ADDR_INT_COAL  = 5'h10;
  localparam logic [4:0] ADDR_RX_PTR    = 5'h11;
  localparam logic [4:0] ADDR_TX_PTR    = 5'h12;

  // int_flag bit positions
  localparam int IF_IDLE    = 0;
  localparam int IF_RX_PEND = 1;
  localparam int IF_RX_BRK  = 2;
  localparam int IF_RX_LOST = 3;
  localparam int IF_RX_ERR  = 4;
  localparam int IF_TX_DONE = 5;
  localparam int IF_CD      = 6;
  localparam int IF_TX_ERR  = 7;

  // Bits of INT_FLAG that are sticky and write-1-to-clear
  localparam logic [7:0] W1C_MASK = 8'hDC;

  // Control bits inside RX_CTRL / TX_CTRL writes
  localparam int CTRL_DONE_SWITCH = 1;
  localparam int CTRL_CLEAN_ABORT = 4;
  localparam int CTRL_BREAK       = 5;

  typedef struct packed {
    logic idle_invert;
    logic full_duplex;
    logic break_sync;
    logic arbitration;
    logic not_drop;
    logic user_crc;
    logic tx_invert;
    logic tx_push_pull;
  } setting_t;

  // Reset values
  localparam logic [7:0] SETTING_RST   = 8'h10;
  localparam logic [7:0] IDLE_WAIT_RST = 8'd10;
  localparam logic [9:0] TX_PERMIT_RST = 10'd20;
  localparam logic [9:0] MAX_IDLE_RST  = 10'd200;
  localparam logic [1:0] TX_PRE_RST    = 2'd1;
  localparam logic [7:0] FILTER_RST    = 8'hFF;

  // Sticky flag update: a set event beats a simultaneous clear
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/cd_csr_v2_if.sv
// CSR bus of the CD controller: word address, read/write strobes and data.
interface cd_csr_v2_if #(
  parameter int DATA_W = 32
) ();
  logic [4:0]        csr_address;
  logic              csr_read;
  logic              csr_write;
  logic [DATA_W-1:0] csr_writedata;
  logic [DATA_W-1:0] csr_readdata;

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata,
    input  csr_readdata
  );

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata,
    output csr_readdata
  );
endinterface

// File: rtl/cd_irq_coal.sv
// Interrupt coalescing: after a reload the request is held off for
// 'period' clocks; a period of zero disables the hold entirely.
module cd_irq_coal
  import cd_csr_pkg::*;
#(
  parameter int COAL_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              reload,
  input  logic [COAL_W-1:0] period,
  output logic              irq
);

  logic [COAL_W-1:0] hold_cnt_d;
  logic [COAL_W-1:0] hold_cnt_q;

  // Next hold count: load on reload, otherwise count down to zero
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (reload) begin
      hold_cnt_d = period;
    end else if (hold_cnt_q != {COAL_W{1'b0}}) begin
      hold_cnt_d = hold_cnt_q - COAL_W'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Hold counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= {COAL_W{1'b0}};
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign irq = req & (hold_cnt_q == {COAL_W{1'b0}});

endmodule

// File: rtl/cd_csr_v2.sv
// CSR block of the CD bus controller: configuration registers, sticky
// interrupt flags with coalescing, and pointer-based RX/TX RAM access.
module cd_csr_v2
  import cd_csr_pkg::*;
#(
  parameter logic [7:0] VERSION = 8'h10,
  parameter int         DATA_W  = 32,
  parameter int         RAM_AW  = 6,
  parameter int         DIV_LS  = 346,
  parameter int         DIV_HS  = 346,
  parameter int         COAL_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  cd_csr_v2_if.slave        csr,
  output logic              irq,
  output logic [7:0]        setting,
  output logic [7:0]        idle_wait_len,
  output logic [9:0]        tx_permit_len,
  output logic [9:0]        max_idle_len,
  output logic [1:0]        tx_pre_len,
  output logic [7:0]        filter,
  output logic [7:0]        filter_m0,
  output logic [7:0]        filter_m1,
  output logic [15:0]       div_ls,
  output logic [15:0]       div_hs,
  output logic [RAM_AW-1:0] rx_ram_rd_addr,
  input  logic [DATA_W-1:0] rx_ram_rd_word,
  input  logic [7:0]        rx_ram_rd_len,
  output logic              rx_ram_rd_done,
  output logic              rx_clean_all,
  output logic              tx_ram_switch,
  output logic              tx_abort,
  output logic              tx_ram_wr_en,
  output logic [RAM_AW-1:0] tx_ram_wr_addr,
  output logic              has_break,
  input  logic              rx_error,
  input  logic              rx_ram_lost,
  input  logic              rx_break,
  input  logic              cd,
  input  logic              tx_err,
  input  logic              ack_break,
  input  logic              rx_pending,
  input  logic              tx_pending,
  input  logic              bus_idle,
  input  logic              rx_ram_rd_err
);

  // Register state
  setting_t          setting_q,   setting_d;
  logic [7:0]        idle_wait_q, idle_wait_d;
  logic [9:0]        tx_permit_q, tx_permit_d;
  logic [9:0]        max_idle_q,  max_idle_d;
  logic [1:0]        tx_pre_q,    tx_pre_d;
  logic [7:0]        filter_q,    filter_d;
  logic [7:0]        filter_m0_q, filter_m0_d;
  logic [7:0]        filter_m1_q, filter_m1_d;
  logic [15:0]       div_ls_q,    div_ls_d;
  logic [15:0]       div_hs_q,    div_hs_d;
  logic [7:0]        int_mask_q,  int_mask_d;
  logic [COAL_W-1:0] int_coal_q,  int_coal_d;
  logic              tx_err_q,    tx_err_d;
  logic              cd_q,        cd_d;
  logic              rx_err_q,    rx_err_d;
  logic              rx_lost_q,   rx_lost_d;
  logic              rx_brk_q,    rx_brk_d;
  logic [RAM_AW-1:0] rx_addr_q,   rx_addr_d;
  logic [RAM_AW-1:0] tx_addr_q,   tx_addr_d;
  logic              rx_done_q,   rx_done_d;
  logic              rx_clean_q,  rx_clean_d;
  logic              tx_switch_q, tx_switch_d;
  logic              tx_abort_q,  tx_abort_d;
  logic              has_break_q, has_break_d;

  // Combinational helpers
  logic [31:0] wdata_s;
  logic [31:0] rdata_s;
  logic [7:0]  int_flag_s;
  logic [7:0]  sticky_vec_s;
  logic [7:0]  clr_s;
  logic        break_set_s;
  logic        tx_wr_en_s;
  logic        irq_req_s;
  logic        reload_s;
  logic        unused_wdata_s;

  // Narrow buses zero-extend; every field then takes its low bits.
  assign wdata_s        = 32'(csr.csr_writedata);
  assign unused_wdata_s = ^wdata_s[31:16];

  // Live interrupt status word
  always_comb begin
    int_flag_s             = 8'h00;
    int_flag_s[IF_TX_ERR]  = tx_err_q;
    int_flag_s[IF_CD]      = cd_q;
    int_flag_s[IF_TX_DONE] = ~tx_pending;
    int_flag_s[IF_RX_ERR]  = setting_q.not_drop ? rx_ram_rd_err : rx_err_q;
    int_flag_s[IF_RX_LOST] = rx_lost_q;
    int_flag_s[IF_RX_BRK]  = rx_brk_q;
    int_flag_s[IF_RX_PEND] = rx_pending;
    int_flag_s[IF_IDLE]    = setting_q.idle_invert ? ~bus_idle : bus_idle;
  end

  // Sticky flags laid out at their int_flag positions
  always_comb begin
    sticky_vec_s             = 8'h00;
    sticky_vec_s[IF_TX_ERR]  = tx_err_q;
    sticky_vec_s[IF_CD]      = cd_q;
    sticky_vec_s[IF_RX_ERR]  = rx_err_q;
    sticky_vec_s[IF_RX_LOST] = rx_lost_q;
    sticky_vec_s[IF_RX_BRK]  = rx_brk_q;
  end

  // Read mux, decoded purely from the address
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (csr.csr_address)
      ADDR_VERSION:   rdata_s = 32'(VERSION);
      ADDR_SETTING:   rdata_s = 32'(setting_q);
      ADDR_IDLE_WAIT: rdata_s = 32'(idle_wait_q);
      ADDR_TX_PERMIT: rdata_s = 32'(tx_permit_q);
      ADDR_MAX_IDLE:  rdata_s = 32'(max_idle_q);
      ADDR_TX_PRE:    rdata_s = 32'(tx_pre_q);
      ADDR_FILTER:    rdata_s = 32'(filter_q);
      ADDR_DIV_LS:    rdata_s = 32'(div_ls_q);
      ADDR_DIV_HS:    rdata_s = 32'(div_hs_q);
      ADDR_INT_MASK:  rdata_s = 32'(int_mask_q);
      ADDR_INT_FLAG:  rdata_s = 32'({rx_ram_rd_len, int_flag_s});
      ADDR_RX:        rdata_s = 32'(rx_ram_rd_word);
      ADDR_TX_CTRL:   rdata_s = 32'({has_break_q, 5'b0_0000});
      ADDR_FILTER_M:  rdata_s = 32'({filter_m1_q, filter_m0_q});
      ADDR_INT_COAL:  rdata_s = 32'(int_coal_q);
      ADDR_RX_PTR:    rdata_s = 32'(rx_addr_q);
      ADDR_TX_PTR:    rdata_s = 32'(tx_addr_q);
      default:        rdata_s = 32'h0000_0000;
    endcase
  end

  assign csr.csr_readdata = DATA_W'(rdata_s);

  // Next-state logic for all registers, pointers and pulses
  always_comb begin
    setting_d   = setting_q;
    idle_wait_d = idle_wait_q;
    tx_permit_d = tx_permit_q;
    max_idle_d  = max_idle_q;
    tx_pre_d    = tx_pre_q;
    filter_d    = filter_q;
    filter_m0_d = filter_m0_q;
    filter_m1_d = filter_m1_q;
    div_ls_d    = div_ls_q;
    div_hs_d    = div_hs_q;
    int_mask_d  = int_mask_q;
    int_coal_d  = int_coal_q;
    rx_addr_d   = rx_addr_q;
    tx_addr_d   = tx_addr_q;
    rx_done_d   = 1'b0;
    rx_clean_d  = 1'b0;
    tx_switch_d = 1'b0;
    tx_abort_d  = 1'b0;
    clr_s       = 8'h00;
    break_set_s = 1'b0;
    tx_wr_en_s  = 1'b0;

    // An RX read consumes the word and advances the read pointer
    if (csr.csr_read && (csr.csr_address == ADDR_RX)) begin
      rx_addr_d = rx_addr_q + RAM_AW'(1);
    end else begin
      rx_addr_d = rx_addr_q;
    end

    if (csr.csr_write) begin
      case (csr.csr_address)
        ADDR_SETTING:   setting_d   = setting_t'(wdata_s[7:0]);
        ADDR_IDLE_WAIT: idle_wait_d = wdata_s[7:0];
        ADDR_TX_PERMIT: tx_permit_d = wdata_s[9:0];
        ADDR_MAX_IDLE:  max_idle_d  = wdata_s[9:0];
        ADDR_TX_PRE:    tx_pre_d    = wdata_s[1:0];
        ADDR_FILTER:    filter_d    = wdata_s[7:0];
        ADDR_DIV_LS:    div_ls_d    = wdata_s[15:0];
        ADDR_DIV_HS:    div_hs_d    = wdata_s[15:0];
        ADDR_INT_MASK:  int_mask_d  = wdata_s[7:0];
        ADDR_INT_FLAG:  clr_s       = wdata_s[7:0] & W1C_MASK;
        ADDR_TX: begin
          tx_wr_en_s = 1'b1;
          tx_addr_d  = tx_addr_q + RAM_AW'(1);
        end
        ADDR_RX_CTRL: begin
          rx_clean_d = wdata_s[CTRL_CLEAN_ABORT];
          rx_done_d  = wdata_s[CTRL_DONE_SWITCH];
          rx_addr_d  = {RAM_AW{1'b0}};
        end
        ADDR_TX_CTRL: begin
          break_set_s = wdata_s[CTRL_BREAK];
          tx_abort_d  = wdata_s[CTRL_CLEAN_ABORT];
          tx_switch_d = wdata_s[CTRL_DONE_SWITCH];
          tx_addr_d   = {RAM_AW{1'b0}};
        end
        ADDR_FILTER_M: begin
          filter_m0_d = wdata_s[7:0];
          filter_m1_d = wdata_s[15:8];
        end
        ADDR_INT_COAL:  int_coal_d  = COAL_W'(wdata_s);
        ADDR_RX_PTR:    rx_addr_d   = RAM_AW'(wdata_s);
        ADDR_TX_PTR:    tx_addr_d   = RAM_AW'(wdata_s);
        default:        clr_s       = 8'h00;
      endcase
    end else begin
      clr_s = 8'h00;
    end

    tx_err_d    = sticky_next(tx_err_q,  tx_err,      clr_s[IF_TX_ERR]);
    cd_d        = sticky_next(cd_q,      cd,          clr_s[IF_CD]);
    rx_err_d    = sticky_next(rx_err_q,  rx_error,    clr_s[IF_RX_ERR]);
    rx_lost_d   = sticky_next(rx_lost_q, rx_ram_lost, clr_s[IF_RX_LOST]);
    rx_brk_d    = sticky_next(rx_brk_q,  rx_break,    clr_s[IF_RX_BRK]);
    has_break_d = break_set_s | (has_break_q & ~ack_break);
  end

  // State registers with asynchronous reset to documented values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      setting_q   <= setting_t'(SETTING_RST);
      idle_wait_q <= IDLE_WAIT_RST;
      tx_permit_q <= TX_PERMIT_RST;
      max_idle_q  <= MAX_IDLE_RST;
      tx_pre_q    <= TX_PRE_RST;
      filter_q    <= FILTER_RST;
      filter_m0_q <= FILTER_RST;
      filter_m1_q <= FILTER_RST;
      div_ls_q    <= 16'(DIV_LS);
      div_hs_q    <= 16'(DIV_HS);
      int_mask_q  <= 8'h00;
      int_coal_q  <= {COAL_W{1'b0}};
      tx_err_q    <= 1'b0;
      cd_q        <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_lost_q   <= 1'b0;
      rx_brk_q    <= 1'b0;
      rx_addr_q   <= {RAM_AW{1'b0}};
      tx_addr_q   <= {RAM_AW{1'b0}};
      rx_done_q   <= 1'b0;
      rx_clean_q  <= 1'b0;
      tx_switch_q <= 1'b0;
      tx_abort_q  <= 1'b0;
      has_break_q <= 1'b0;
    end else begin
      setting_q   <= setting_d;
      idle_wait_q <= idle_wait_d;
      tx_permit_q <= tx_permit_d;
      max_idle_q  <= max_idle_d;
      tx_pre_q    <= tx_pre_d;
      filter_q    <= filter_d;
      filter_m0_q <= filter_m0_d;
      filter_m1_q <= filter_m1_d;
      div_ls_q    <= div_ls_d;
      div_hs_q    <= div_hs_d;
      int_mask_q  <= int_mask_d;
      int_coal_q  <= int_coal_d;
      tx_err_q    <= tx_err_d;
      cd_q        <= cd_d;
      rx_err_q    <= rx_err_d;
      rx_lost_q   <= rx_lost_d;
      rx_brk_q    <= rx_brk_d;
      rx_addr_q   <= rx_addr_d;
      tx_addr_q   <= tx_addr_d;
      rx_done_q   <= rx_done_d;
      rx_clean_q  <= rx_clean_d;
      tx_switch_q <= tx_switch_d;
      tx_abort_q  <= tx_abort_d;
      has_break_q <= has_break_d;
    end
  end

  // Coalescing: a W1C that actually clears a masked, set flag starts the hold.
  assign irq_req_s = |(int_flag_s & int_mask_q);
  assign reload_s  = |(clr_s & int_mask_q & sticky_vec_s);

  cd_irq_coal #(
    .COAL_W (COAL_W)
  ) u_coal (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (irq_req_s),
    .reload  (reload_s),
    .period  (int_coal_q),
    .irq     (irq)
  );

  assign setting        = setting_q;
  assign idle_wait_len  = idle_wait_q;
  assign tx_permit_len  = tx_permit_q;
  assign max_idle_len   = max_idle_q;
  assign tx_pre_len     = tx_pre_q;
  assign filter         = filter_q;
  assign filter_m0      = filter_m0_q;
  assign filter_m1      = filter_m1_q;
  assign div_ls         = div_ls_q;
  assign div_hs         = div_hs_q;
  assign rx_ram_rd_addr = rx_addr_q;
  assign tx_ram_wr_addr = tx_addr_q;
  assign rx_ram_rd_done = rx_done_q;
  assign rx_clean_all   = rx_clean_q;
  assign tx_ram_switch  = tx_switch_q;
  assign tx_abort       = tx_abort_q;
  assign tx_ram_wr_en   = tx_wr_en_s;
  assign has_break      = has_break_q;

endmodule

// File: tb/tb_cd_csr_v2.sv
// Scoreboard bench for cd_csr_v2: two instances (32-bit bus with a 4-word
// RAM window, and an 8-bit bus) share all stimulus; expectations are queued
// by the stimulus and drained by a negedge monitor.
module tb_cd_csr_v2;
  import cd_csr_pkg::*;

  localparam int S_RDA = 0, S_RDB = 1, S_IRQ = 2, S_RXA = 3, S_TXA = 4, S_HB = 5;
  localparam int S_TXPRE = 6, S_DIVA = 7, S_DIVB = 8, S_TXEN = 9, S_TXAB = 10, S_TXSW = 11;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  addr;
  logic        rd, wr, probe_v;
  logic [31:0] wdata;
  logic        rx_error, rx_ram_lost, rx_break, cd, tx_err, ack_break;
  logic        rx_pending, tx_pending, bus_idle, rx_ram_rd_err;
  logic [7:0]  rx_len;
  logic [31:0] rx_word;

  cd_csr_v2_if #(.DATA_W(32)) if_a ();
  cd_csr_v2_if #(.DATA_W(8))  if_b ();

  assign if_a.csr_address   = addr;
  assign if_a.csr_read      = rd;
  assign if_a.csr_write     = wr;
  assign if_a.csr_writedata = wdata;
  assign if_b.csr_address   = addr;
  assign if_b.csr_read      = rd;
  assign if_b.csr_write     = wr;
  assign if_b.csr_writedata = wdata[7:0];

  // Instance A outputs
  logic        a_irq, a_rx_done, a_rx_clean, a_tx_sw, a_tx_abort, a_tx_en, a_hb;
  logic [7:0]  a_setting, a_idle_wait, a_filter, a_fm0, a_fm1;
  logic [9:0]  a_tx_permit, a_max_idle;
  logic [1:0]  a_tx_pre;
  logic [15:0] a_div_ls, a_div_hs;
  logic [1:0]  a_rx_addr, a_tx_addr;
  // Instance B outputs
  logic        b_irq, b_rx_done, b_rx_clean, b_tx_sw, b_tx_abort, b_tx_en, b_hb;
  logic [7:0]  b_setting, b_idle_wait, b_filter, b_fm0, b_fm1;
  logic [9:0]  b_tx_permit, b_max_idle;
  logic [1:0]  b_tx_pre;
  logic [15:0] b_div_ls, b_div_hs;
  logic [5:0]  b_rx_addr, b_tx_addr;

  // RX RAM model for instance A: word content encodes its address
  assign rx_word = 32'hBEEF_0000 | 32'(a_rx_addr);

  cd_csr_v2 #(.DATA_W(32), .RAM_AW(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .csr(if_a), .irq(a_irq), .setting(a_setting),
    .idle_wait_len(a_idle_wait), .tx_permit_len(a_tx_permit), .max_idle_len(a_max_idle),
    .tx_pre_len(a_tx_pre), .filter(a_filter), .filter_m0(a_fm0), .filter_m1(a_fm1),
    .div_ls(a_div_ls), .div_hs(a_div_hs), .rx_ram_rd_addr(a_rx_addr),
    .rx_ram_rd_word(rx_word), .rx_ram_rd_len(rx_len), .rx_ram_rd_done(a_rx_done),
    .rx_clean_all(a_rx_clean), .tx_ram_switch(a_tx_sw), .tx_abort(a_tx_abort),
    .tx_ram_wr_en(a_tx_en), .tx_ram_wr_addr(a_tx_addr), .has_break(a_hb),
    .rx_error(rx_error), .rx_ram_lost(rx_ram_lost), .rx_break(rx_break), .cd(cd),
    .tx_err(tx_err), .ack_break(ack_break), .rx_pending(rx_pending),
    .tx_pending(tx_pending), .bus_idle(bus_idle), .rx_ram_rd_err(rx_ram_rd_err)
  );

  cd_csr_v2 #(.DATA_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .csr(if_b), .irq(b_irq), .setting(b_setting),
    .idle_wait_len(b_idle_wait), .tx_permit_len(b_tx_permit), .max_idle_len(b_max_idle),
    .tx_pre_len(b_tx_pre), .filter(b_filter), .filter_m0(b_fm0), .filter_m1(b_fm1),
    .div_ls(b_div_ls), .div_hs(b_div_hs), .rx_ram_rd_addr(b_rx_addr),
    .rx_ram_rd_word(rx_word[7:0]), .rx_ram_rd_len(rx_len), .rx_ram_rd_done(b_rx_done),
    .rx_clean_all(b_rx_clean), .tx_ram_switch(b_tx_sw), .tx_abort(b_tx_abort),
    .tx_ram_wr_en(b_tx_en), .tx_ram_wr_addr(b_tx_addr), .has_break(b_hb),
    .rx_error(rx_error), .rx_ram_lost(rx_ram_lost), .rx_break(rx_break), .cd(cd),
    .tx_err(tx_err), .ack_break(ack_break), .rx_pending(rx_pending),
    .tx_pending(tx_pending), .bus_idle(bus_idle), .rx_ram_rd_err(rx_ram_rd_err)
  );

  function automatic logic [31:0] sample(input int s);
    case (s)
      S_RDA:   sample = if_a.csr_readdata;
      S_RDB:   sample = 32'(if_b.csr_readdata);
      S_IRQ:   sample = 32'(a_irq);
      S_RXA:   sample = 32'(a_rx_addr);
      S_TXA:   sample = 32'(a_tx_addr);
      S_HB:    sample = 32'(a_hb);
      S_TXPRE: sample = 32'(a_tx_pre);
      S_DIVA:  sample = 32'(a_div_ls);
      S_DIVB:  sample = 32'(b_div_ls);
      S_TXEN:  sample = 32'(a_tx_en);
      S_TXAB:  sample = 32'(a_tx_abort);
      S_TXSW:  sample = 32'(a_tx_sw);
      default: sample = 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void expect_v(input string n, input int s, input logic [31:0] e);
    exp_t it;
    it.name = n;
    it.sel  = s;
    it.exp  = e;
    exp_q.push_back(it);
  endfunction

  // Monitor: whenever a read or probe is presented, drain and compare
  exp_t        mon_it;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    if (rd || probe_v) begin
      while (exp_q.size() > 0) begin
        mon_it  = exp_q.pop_front();
        mon_act = sample(mon_it.sel);
        n_chk++;
        if (mon_act !== mon_it.exp) begin
          n_fail++;
          $display("FAIL %s: actual %h required %h", mon_it.name, mon_act, mon_it.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    probe_v = 1'b1;
    cyc();
    probe_v = 1'b0;
  endtask

  task automatic csr_wr(input logic [4:0] a, input logic [31:0] d, input bit pr);
    addr = a; wdata = d; wr = 1'b1; probe_v = pr;
    cyc();
    wr = 1'b0; probe_v = 1'b0;
  endtask

  task automatic csr_rd(input logic [4:0] a, input string n, input logic [31:0] ea,
                        input logic [31:0] eb);
    expect_v(n, S_RDA, ea);
    expect_v({n, "_b"}, S_RDB, eb);
    addr = a; rd = 1'b1;
    cyc();
    rd = 1'b0;
  endtask

  initial begin
    addr = 5'd0; rd = 1'b0; wr = 1'b0; probe_v = 1'b0; wdata = 32'h0;
    rx_error = 1'b0; rx_ram_lost = 1'b0; rx_break = 1'b0; cd = 1'b0; tx_err = 1'b0;
    ack_break = 1'b0; rx_pending = 1'b0; tx_pending = 1'b1; bus_idle = 1'b0;
    rx_ram_rd_err = 1'b0; rx_len = 8'h07;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    expect_v("rst_irq", S_IRQ, 32'd0);
    expect_v("rst_rx_addr", S_RXA, 32'd0);
    expect_v("rst_has_break", S_HB, 32'd0);
    expect_v("rst_tx_pre", S_TXPRE, 32'd1);
    probe();
    csr_rd(ADDR_VERSION, "version", 32'h10, 32'h10);
    csr_rd(ADDR_SETTING, "setting", 32'h10, 32'h10);
    csr_rd(ADDR_DIV_LS, "div_ls_rst", 32'd346, 32'h5A);
    csr_wr(ADDR_TX_PRE, 32'd3, 1'b0);
    expect_v("tx_pre_len", S_TXPRE, 32'd3);
    probe();

    // RX reads walk and wrap the 4-word window
    for (int i = 0; i < 5; i++) begin
      expect_v("rx_addr", S_RXA, 32'(i % 4));
      csr_rd(ADDR_RX, "rx_word", 32'hBEEF_0000 | 32'(i % 4), 32'(i % 4));
    end
    expect_v("rx_addr_wrap", S_RXA, 32'd1);
    probe();

    // Set event beats a simultaneous W1C
    cd = 1'b1;
    csr_wr(ADDR_INT_FLAG, 32'h40, 1'b0);
    cd = 1'b0;
    csr_rd(ADDR_INT_FLAG, "cd_set_wins", 32'h0000_0740, 32'h40);
    csr_wr(ADDR_INT_FLAG, 32'h40, 1'b0);
    csr_rd(ADDR_INT_FLAG, "cd_cleared", 32'h0000_0700, 32'h00);

    // Coalescing: hold of 4 clocks after a W1C of a masked flag
    csr_wr(ADDR_INT_MASK, 32'h40, 1'b0);
    csr_wr(ADDR_INT_COAL, 32'd4, 1'b0);
    cd = 1'b1; cyc(); cd = 1'b0;
    expect_v("irq_on", S_IRQ, 32'd1);
    probe();
    csr_wr(ADDR_INT_FLAG, 32'h40, 1'b0);
    cd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_v("irq_hold", S_IRQ, 32'd0);
      probe();
      cd = 1'b0;
    end
    expect_v("irq_release", S_IRQ, 32'd1);
    probe();

    // Break request: set beats simultaneous ack, later ack clears
    ack_break = 1'b1;
    csr_wr(ADDR_TX_CTRL, 32'h20, 1'b0);
    ack_break = 1'b0;
    expect_v("break_set", S_HB, 32'd1);
    probe();
    ack_break = 1'b1; cyc(); ack_break = 1'b0;
    expect_v("break_ack", S_HB, 32'd0);
    probe();

    // TX writes, then TX_CTRL pulses and pointer clear
    expect_v("tx_wr_en", S_TXEN, 32'd1);
    csr_wr(ADDR_TX, 32'hAB, 1'b1);
    csr_wr(ADDR_TX, 32'hCD, 1'b0);
    expect_v("tx_addr_inc", S_TXA, 32'd2);
    expect_v("tx_wr_en_idle", S_TXEN, 32'd0);
    probe();
    csr_wr(ADDR_TX_CTRL, 32'h12, 1'b0);
    expect_v("tx_abort_pulse", S_TXAB, 32'd1);
    expect_v("tx_switch_pulse", S_TXSW, 32'd1);
    expect_v("tx_addr_clr", S_TXA, 32'd0);
    probe();
    expect_v("tx_abort_end", S_TXAB, 32'd0);
    expect_v("tx_switch_end", S_TXSW, 32'd0);
    probe();

    // Width truncation on the 8-bit instance
    csr_wr(ADDR_DIV_LS, 32'h1234, 1'b0);
    expect_v("div_ls_a", S_DIVA, 32'h1234);
    expect_v("div_ls_b", S_DIVB, 32'h0034);
    probe();
    csr_rd(ADDR_DIV_LS, "div_ls_rd", 32'h1234, 32'h34);

    // Unmapped address, pointer access, config readback
    csr_wr(5'h1F, 32'hFFFF_FFFF, 1'b0);
    csr_rd(5'h1F, "unmapped", 32'h0, 32'h0);
    csr_wr(ADDR_RX_PTR, 32'd2, 1'b0);
    csr_rd(ADDR_RX_PTR, "rx_ptr", 32'd2, 32'd2);
    csr_rd(ADDR_INT_COAL, "int_coal", 32'd4, 32'd4);
    csr_rd(ADDR_INT_MASK, "int_mask", 32'h40, 32'h40);

    // Reset in the middle of a TX_CTRL write
    expect_v("irq_pre_rst", S_IRQ, 32'd1);
    probe();
    addr = ADDR_TX_CTRL; wdata = 32'h22; wr = 1'b1;
    #2 reset_n = 1'b0;
    expect_v("irq_in_rst", S_IRQ, 32'd0);
    expect_v("tx_sw_in_rst", S_TXSW, 32'd0);
    expect_v("hb_in_rst", S_HB, 32'd0);
    probe_v = 1'b1;
    @(negedge clk);
    #1 wr = 1'b0; probe_v = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc();
    expect_v("tx_sw_after_rst", S_TXSW, 32'd0);
    expect_v("hb_after_rst", S_HB, 32'd0);
    expect_v("irq_after_rst", S_IRQ, 32'd0);
    expect_v("tx_pre_after_rst", S_TXPRE, 32'd1);
    probe();
    csr_rd(ADDR_INT_COAL, "coal_after_rst", 32'd0, 32'd0);
    csr_rd(ADDR_DIV_LS, "div_ls_after_rst", 32'd346, 32'h5A);

    repeat (2) cyc();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
